// File: rtl/regfile_banked.sv
// regfile_banked: dual-bank (integer / floating-point) register file for the
// decode stage. Two registered read ports with independent bank select, one
// write port with write-to-read bypass, and a post-reset sweep that zeroes both
// banks while `busy` is high.
module regfile_banked #(
    parameter int WIDTH              = 32,
    parameter int ADDR_W             = 5,
    parameter int INT_ZERO_HARDWIRED = 1,
    parameter int FP_ZERO_HARDWIRED  = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    input  logic              wr_en,
    input  logic              wr_float,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              rd_float1,
    input  logic              rd_float2,
    output logic [WIDTH-1:0]  rd_data1,
    output logic [WIDTH-1:0]  rd_data2
);

    localparam int DEPTH = 2 ** ADDR_W;
    // One extra counter bit keeps the terminal-count compare free of wrap-around.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   clrCnt;
    logic [ADDR_W-1:0] clrIdx;
    logic [WIDTH-1:0]  intBank [DEPTH];
    logic [WIDTH-1:0]  fpBank  [DEPTH];

    logic             wrAccept;
    logic             wrHit1;
    logic             wrHit2;
    logic [WIDTH-1:0] nextRd1;
    logic [WIDTH-1:0] nextRd2;

    // True when (bank, address) names an entry that is tied to zero.
    function automatic logic isZeroEntry(input logic isFloat, input logic [ADDR_W-1:0] addr);
        if (addr != '0) begin
            return 1'b0;
        end
        return isFloat ? (FP_ZERO_HARDWIRED != 0) : (INT_ZERO_HARDWIRED != 0);
    endfunction

    assign clrIdx   = clrCnt[ADDR_W-1:0];
    // Writes land only in IDLE; reset at the same edge wins and the write is lost.
    assign wrAccept = !rst && (state == IDLE) && wr_en && !isZeroEntry(wr_float, wr_addr);
    assign wrHit1   = wr_en && (wr_float == rd_float1) && (wr_addr == rd_addr1);
    assign wrHit2   = wr_en && (wr_float == rd_float2) && (wr_addr == rd_addr2);

    // Next read data per port: zero entry beats bypass, bypass beats the array.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        nextRd1 = rd_float1 ? fpBank[rd_addr1] : intBank[rd_addr1];
        nextRd2 = rd_float2 ? fpBank[rd_addr2] : intBank[rd_addr2];
        if (wrHit1) begin
            nextRd1 = wr_data;
        end
        if (wrHit2) begin
            nextRd2 = wr_data;
        end
        if (isZeroEntry(rd_float1, rd_addr1)) begin
            nextRd1 = '0;
        end
        if (isZeroEntry(rd_float2, rd_addr2)) begin
            nextRd2 = '0;
        end
    end

    // Bank storage: sweep zeroes one entry per edge in CLEAR, normal writes in IDLE.
    always_ff @(posedge clk) begin
        // NOTE: the arrays take no reset term; the clear sweep defines their contents,
        // which keeps them mappable onto plain RAM.
        if (!rst && state == CLEAR) begin
            intBank[clrIdx] <= '0;
            fpBank[clrIdx]  <= '0;
        end else if (wrAccept) begin
            if (wr_float) begin
                fpBank[wr_addr] <= wr_data;
            end else begin
                intBank[wr_addr] <= wr_data;
            end
        end
    end

    // Control FSM with registered busy and read-data outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state    <= CLEAR;
            clrCnt   <= '0;
            busy     <= 1'b1;
            rd_data1 <= '0;
            rd_data2 <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    rd_data1 <= '0;
                    rd_data2 <= '0;
                    clrCnt   <= clrCnt + 1'b1;
                    if (clrCnt == LAST_IDX) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (rd_en) begin
                        rd_data1 <= nextRd1;
                        rd_data2 <= nextRd2;
                    end
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_banked.sv
// tb_regfile_banked: directed-vector bench for regfile_banked. A second instance
// with FP_ZERO_HARDWIRED=1 shares all inputs so the float zero rule is covered
// in both settings.
module tb_regfile_banked;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        wr_float;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        rd_float1;
    logic        rd_float2;

    logic        busy;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        busyFz;
    logic [31:0] rdData1Fz;
    logic [31:0] rdData2Fz;

    int vectorCount = 0;
    int missCount   = 0;

    regfile_banked dut (
        .clk(clk), .rst(rst), .busy(busy),
        .wr_en(wr_en), .wr_float(wr_float), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_float1(rd_float1), .rd_float2(rd_float2),
        .rd_data1(rd_data1), .rd_data2(rd_data2)
    );

    regfile_banked #(.FP_ZERO_HARDWIRED(1)) dutFz (
        .clk(clk), .rst(rst), .busy(busyFz),
        .wr_en(wr_en), .wr_float(wr_float), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_float1(rd_float1), .rd_float2(rd_float2),
        .rd_data1(rdData1Fz), .rd_data2(rdData2Fz)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeReg(input logic isFloat, input logic [4:0] addr, input logic [31:0] data);
        wr_en = 1'b1; wr_float = isFloat; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic readRegs(input logic f1, input logic [4:0] a1, input logic f2, input logic [4:0] a2);
        rd_en = 1'b1; rd_float1 = f1; rd_addr1 = a1; rd_float2 = f2; rd_addr2 = a2;
        tick();
        rd_en = 1'b0;
    endtask

    // Tick until busy drops; edges = edge number where it dropped, 0 if never.
    task automatic waitClear(output int edges);
        edges = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (busy === 1'b0) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int edges;
        rst = 1'b1;
        tick();
        vectorCount++;
        if (busy !== 1'b1) begin missCount++; $display("FAIL reset_busy: got %b expected 1", busy); end
        vectorCount++;
        if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
            missCount++; $display("FAIL reset_rd: got %h/%h expected 0/0", rd_data1, rd_data2);
        end
        rst = 1'b0;
        waitClear(edges);
        vectorCount++;
        if (edges != 32) begin missCount++; $display("FAIL clear_edges: got %0d expected 32", edges); end
        vectorCount++;
        if (busyFz !== 1'b0) begin missCount++; $display("FAIL clear_busy_fz: got %b expected 0", busyFz); end
        for (int i = 0; i < 32; i++) begin
            readRegs(1'b0, 5'(i), 1'b1, 5'(i));
            vectorCount++;
            if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
                missCount++; $display("FAIL clear_entry_%0d: got %h/%h expected 0/0", i, rd_data1, rd_data2);
            end
        end
    endtask

    task automatic test_banks();
        writeReg(1'b0, 5'd5, 32'hDEADBEEF);
        writeReg(1'b1, 5'd5, 32'h3F800000);
        readRegs(1'b0, 5'd5, 1'b1, 5'd5);
        vectorCount++;
        if (rd_data1 !== 32'hDEADBEEF) begin missCount++; $display("FAIL bank_int5: got %h expected deadbeef", rd_data1); end
        vectorCount++;
        if (rd_data2 !== 32'h3F800000) begin missCount++; $display("FAIL bank_fp5: got %h expected 3f800000", rd_data2); end
        vectorCount++;
        if (rdData2Fz !== 32'h3F800000) begin missCount++; $display("FAIL bank_fp5_fz: got %h expected 3f800000", rdData2Fz); end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_float = 1'b0; wr_addr = 5'd7; wr_data = 32'h12345678;
        rd_en = 1'b1; rd_float1 = 1'b0; rd_addr1 = 5'd7; rd_float2 = 1'b1; rd_addr2 = 5'd7;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        vectorCount++;
        if (rd_data1 !== 32'h12345678) begin missCount++; $display("FAIL bypass_int7: got %h expected 12345678", rd_data1); end
        vectorCount++;
        if (rd_data2 !== 32'h0) begin missCount++; $display("FAIL bypass_fp7: got %h expected 00000000", rd_data2); end
        readRegs(1'b1, 5'd7, 1'b0, 5'd7);
        vectorCount++;
        if (rd_data1 !== 32'h0 || rd_data2 !== 32'h12345678) begin
            missCount++; $display("FAIL stored_int7: got %h/%h expected 00000000/12345678", rd_data1, rd_data2);
        end
    endtask

    task automatic test_zero();
        writeReg(1'b0, 5'd0, 32'hFFFFFFFF);
        readRegs(1'b0, 5'd0, 1'b0, 5'd0);
        vectorCount++;
        if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
            missCount++; $display("FAIL int0_stored: got %h/%h expected 0/0", rd_data1, rd_data2);
        end
        // Same-cycle write and read of int[0]: the zero rule beats bypass.
        wr_en = 1'b1; wr_float = 1'b0; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rd_en = 1'b1; rd_float1 = 1'b0; rd_addr1 = 5'd0; rd_float2 = 1'b0; rd_addr2 = 5'd7;
        tick();
        vectorCount++;
        if (rd_data1 !== 32'h0) begin missCount++; $display("FAIL int0_bypass: got %h expected 00000000", rd_data1); end
        // Same-cycle write and read of fp[0]: ordinary entry in dut, zero in dutFz.
        wr_float = 1'b1;
        rd_float1 = 1'b0; rd_addr1 = 5'd7; rd_float2 = 1'b1; rd_addr2 = 5'd0;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        vectorCount++;
        if (rd_data2 !== 32'hFFFFFFFF) begin missCount++; $display("FAIL fp0_bypass: got %h expected ffffffff", rd_data2); end
        vectorCount++;
        if (rdData2Fz !== 32'h0) begin missCount++; $display("FAIL fp0_bypass_fz: got %h expected 00000000", rdData2Fz); end
        vectorCount++;
        if (rd_data1 !== 32'h12345678) begin missCount++; $display("FAIL fp0_port1: got %h expected 12345678", rd_data1); end
        readRegs(1'b1, 5'd0, 1'b1, 5'd0);
        vectorCount++;
        if (rd_data1 !== 32'hFFFFFFFF || rd_data2 !== 32'hFFFFFFFF) begin
            missCount++; $display("FAIL fp0_stored: got %h/%h expected ffffffff/ffffffff", rd_data1, rd_data2);
        end
        vectorCount++;
        if (rdData1Fz !== 32'h0 || rdData2Fz !== 32'h0) begin
            missCount++; $display("FAIL fp0_stored_fz: got %h/%h expected 0/0", rdData1Fz, rdData2Fz);
        end
    endtask

    task automatic test_rd_hold();
        writeReg(1'b0, 5'd9, 32'hCAFEF00D);
        readRegs(1'b0, 5'd9, 1'b0, 5'd5);
        vectorCount++;
        if (rd_data1 !== 32'hCAFEF00D) begin missCount++; $display("FAIL hold_load: got %h expected cafef00d", rd_data1); end
        writeReg(1'b0, 5'd9, 32'h11111111);
        tick();
        vectorCount++;
        if (rd_data1 !== 32'hCAFEF00D || rd_data2 !== 32'hDEADBEEF) begin
            missCount++; $display("FAIL hold_keep: got %h/%h expected cafef00d/deadbeef", rd_data1, rd_data2);
        end
        readRegs(1'b0, 5'd9, 1'b0, 5'd9);
        vectorCount++;
        if (rd_data1 !== 32'h11111111 || rd_data2 !== 32'h11111111) begin
            missCount++; $display("FAIL hold_reload: got %h/%h expected 11111111/11111111", rd_data1, rd_data2);
        end
    endtask

    task automatic test_mid_sweep();
        int edges;
        writeReg(1'b0, 5'd3, 32'h00000055);
        rst = 1'b1;
        tick();
        vectorCount++;
        if (busy !== 1'b1 || rd_data1 !== 32'h0) begin
            missCount++; $display("FAIL rerst_state: got busy=%b rd1=%h expected busy=1 rd1=0", busy, rd_data1);
        end
        rst = 1'b0;
        // Writes and reads requested throughout the sweep must be ignored.
        wr_en = 1'b1; wr_float = 1'b0; wr_addr = 5'd3; wr_data = 32'h000000AA;
        rd_en = 1'b1; rd_float1 = 1'b0; rd_addr1 = 5'd3; rd_float2 = 1'b0; rd_addr2 = 5'd5;
        for (int i = 0; i < 10; i++) tick();
        vectorCount++;
        if (busy !== 1'b1 || rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
            missCount++; $display("FAIL sweep_outputs: got busy=%b rd=%h/%h expected 1 0/0", busy, rd_data1, rd_data2);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        waitClear(edges);
        wr_en = 1'b0; rd_en = 1'b0;
        vectorCount++;
        if (edges != 32) begin missCount++; $display("FAIL restart_edges: got %0d expected 32", edges); end
        readRegs(1'b0, 5'd3, 1'b0, 5'd5);
        vectorCount++;
        if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
            missCount++; $display("FAIL sweep_write_lost: got %h/%h expected 0/0", rd_data1, rd_data2);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_float = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr1 = '0; rd_addr2 = '0; rd_float1 = 1'b0; rd_float2 = 1'b0;
        test_reset();
        test_banks();
        test_bypass();
        test_zero();
        test_rd_hold();
        test_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/regfile_banked.md
# regfile_banked

Parametrised dual-bank (integer / floating-point) register file for the datapath decode stage. It replaces the single-width 32x32 design with configurable width and depth. Each read port selects its bank independently, and reads are registered with write-to-read bypass. A hardware clear sweep zeroes both banks after reset and reports progress on `busy`.

## Interface
Parameters:
- `WIDTH`, 32, data width of every entry.
- `ADDR_W`, 5, address width; depth per bank is `DEPTH = 2**ADDR_W`.
- `INT_ZERO_HARDWIRED`, 1, when 1, integer entry 0 always reads 0 and writes to it are dropped.
- `FP_ZERO_HARDWIRED`, 0, same rule for float entry 0; when 0, float entry 0 is an ordinary register.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `busy` out 1: high while reset is asserted or the clear sweep is running.
- `wr_en` in 1: write request.
- `wr_float` in 1: write bank select; 1 selects the float bank, 0 the integer bank.
- `wr_addr` in ADDR_W: write address.
- `wr_data` in WIDTH: write data.
- `rd_en` in 1: read-port update enable, shared by both ports.
- `rd_addr1`, `rd_addr2` in ADDR_W: read addresses.
- `rd_float1`, `rd_float2` in 1: per-port bank select.
- `rd_data1`, `rd_data2` out WIDTH: registered read data.

## Operation
- Storage: two arrays, `int_bank` and `fp_bank`, each DEPTH x WIDTH. There is no initial-block preload; contents are defined only by the clear sweep.
- FSM states are CLEAR and IDLE.
  - `rst`=1 at an edge: state becomes CLEAR, `clr_cnt` becomes 0, `busy` becomes 1, and both `rd_data` outputs become 0. Nothing is written while `rst` is held.
  - CLEAR with `rst`=0: each edge writes 0 to `int_bank[clr_cnt]` and `fp_bank[clr_cnt]`, then increments `clr_cnt`.
  - On the edge that writes entry DEPTH-1, state becomes IDLE and `busy` becomes 0.
  - IDLE: stays IDLE until `rst`.
- Write path (IDLE only): if `wr_en`=1 at an edge, `wr_data` goes to the selected bank at `wr_addr`, unless the target is a hardwired-zero entry, in which case the write is silently dropped.
- During CLEAR, `wr_en` is ignored and the write is lost; there is no retry or queue.
- Read path (IDLE only): if `rd_en`=1 at an edge, each port `n` loads `rd_data<n>` as follows, in priority order:
  1. 0 if (`rd_float<n>`, `rd_addr<n>`) is a hardwired-zero entry;
  2. else `wr_data` if `wr_en`=1 and the write targets the same bank and address (bypass, new data wins);
  3. else the stored entry.
- If `rd_en`=0, both outputs hold their value.
- During CLEAR, both `rd_data` outputs are forced to 0 every edge, regardless of `rd_en`.
- Both ports may address the same entry; both then return identical data.
- No arithmetic; `clr_cnt` is ADDR_W+1 bits wide so the terminal-count compare against DEPTH-1 is exact.

## Timing
- Reset values: `busy`=1, `rd_data1`=`rd_data2`=0, state CLEAR, `clr_cnt`=0.
- Clear duration: exactly DEPTH edges after the first edge with `rst`=0. `busy` is first low after edge DEPTH, which is 32 for the default parameters.
- Reset mid-sweep: the sweep restarts at entry 0 and takes the full DEPTH edges again. Partial progress is not retained.
- Write latency: data is stored at edge N and is visible through the array path on a read sampled at edge N+1.
- Read latency: 1 cycle. Address at edge N gives data on `rd_data` after edge N.
- With bypass, a write and a read of the same entry at edge N return the new data after edge N.
- `rst` and `wr_en` at the same edge: reset wins and the write is dropped.
- First edge after `busy` falls: full read and write service; no extra bubble.

## Test plan
- Reset/clear sweep: pulse `rst` 1 cycle, then count edges with `busy`=1 → exactly 32 (ADDR_W=5). After that, reading int and fp entries 0..31 → all 0x00000000.
- Bank independence: write int[5]=0xDEADBEEF, then fp[5]=0x3F800000. Read port1 int[5] and port2 fp[5] in the same cycle → 0xDEADBEEF and 0x3F800000 one cycle later.
- Bypass: at one edge, `wr_en` to int[7]=0x12345678 with port1 reading int[7] and port2 reading fp[7] → port1 0x12345678, port2 0 after that edge.
- Zero rules, defaults: write int[0]=0xFFFFFFFF then read → 0, including the same-cycle bypass case. Write fp[0]=0xFFFFFFFF then read → 0xFFFFFFFF. Rerun with FP_ZERO_HARDWIRED=1 → 0.
- Reset mid-sweep: assert `rst` at sweep edge 10 → `busy` stays high for 32 further edges after release. A `wr_en` during the sweep to int[3]=0xAA has no effect, so int[3] reads 0.
- `rd_en` hold: load `rd_data1`=0xCAFEF00D, then drop `rd_en` and overwrite that entry → `rd_data1` stays 0xCAFEF00D until `rd_en` is reasserted.
